// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encodings and the bit-counter width helper.
package serial_add_ctrl_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits are enough.
   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Command/result bundle between the pin mapping (master) and the
// serial add/subtract controller (slave).
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   import serial_add_ctrl_pkg::*;

   // start is a one-sided strobe taken only while the slave is idle; sub, op_a
   // and op_b are sampled on that same edge. busy marks the bit-serial run, and
   // done pulses for one cycle when sum/cout/ovf become valid; they hold until
   // the next accepted start.
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   state_t           state;

   modport master (
      output start, sub, op_a, op_b,
      input  busy, done, sum, cout, ovf, state
   );

   modport slave (
      input  start, sub, op_a, op_b,
      output busy, done, sum, cout, ovf, state
   );

endinterface

// File: rtl/serial_add_ctrl_bit_full_adder.sv
// Single-bit full adder cell; the only arithmetic in the serial controller.
module bit_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell stepped LSB first
// over WIDTH cycles, with a registered carry linking consecutive bits.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   serial_add_ctrl_if.slave bus
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
   localparam logic [CW-1:0] MSB_STEP  = CW'(WIDTH - 2);

   state_t           state_q;
   logic [WIDTH-1:0] shift_a;
   logic [WIDTH-1:0] shift_b;
   logic [WIDTH-1:0] sum_q;
   logic [CW-1:0]    count;
   logic             carry;
   logic             c_msb_in;
   logic             cout_q;
   logic             ovf_q;
   logic             fa_s;
   logic             fa_c;

   bit_full_adder u_fa (
      .a    (shift_a[0]),
      .b    (shift_b[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         shift_a  <= '0;
         shift_b  <= '0;
         sum_q    <= '0;
         count    <= '0;
         carry    <= 1'b0;
         c_msb_in <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  // Subtraction is A + ~B + 1: invert B and seed the carry.
                  shift_a <= bus.op_a;
                  shift_b <= bus.op_b ^ {WIDTH{bus.sub}};
                  carry   <= bus.sub;
                  count   <= '0;
                  sum_q   <= '0;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
               shift_a <= shift_a >> 1;
               shift_b <= shift_b >> 1;
               carry   <= fa_c;
               count   <= count + 1'b1;
               // Carry produced by bit WIDTH-2 is the carry into the sign bit.
               if (count == MSB_STEP) begin
                  c_msb_in <= fa_c;
               end
               if (count == LAST_STEP) begin
                  cout_q  <= fa_c;
                  ovf_q   <= fa_c ^ c_msb_in;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = (state_q == ST_RUN);
   assign bus.done  = (state_q == ST_DONE);
   assign bus.sum   = sum_q;
   assign bus.cout  = cout_q;
   assign bus.ovf   = ovf_q;
   assign bus.state = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 with hand-computed results.
module tb_serial_add_ctrl;
   import serial_add_ctrl_pkg::*;

   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // driver: present a command for exactly one edge, then scramble the operands
   task automatic start_cmd(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bus.start = 1'b1;
      bus.sub   = s;
      bus.op_a  = a;
      bus.op_b  = b;
      tick();
      bus.start = 1'b0;
      bus.sub   = 1'($urandom_range(0, 1));
      bus.op_a  = WIDTH'($urandom_range(0, 255));
      bus.op_b  = WIDTH'($urandom_range(0, 255));
   endtask

   task automatic run_cmd(input string tag, input logic s, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
      start_cmd(s, a, b);
      for (int i = 0; i < WIDTH; i++) begin
         check({tag, "_busy_done_run"}, {30'd0, bus.busy, bus.done}, 32'd2);
         tick();
      end
      check({tag, "_busy_done_at_done"}, {30'd0, bus.busy, bus.done}, 32'd1);
      check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
      check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
      tick();
      check({tag, "_idle_state"}, 32'(bus.state), 32'(ST_IDLE));
      check({tag, "_busy_done_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
      check({tag, "_sum_held"}, 32'(bus.sum), 32'(exp_sum));
   endtask

   initial begin
      logic seen_done;
      logic seen_idle;
      int   spacing;

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      tick();
      tick();
      check("rst_state", 32'(bus.state), 32'(ST_IDLE));
      check("rst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
      check("rst_sum", 32'(bus.sum), 32'd0);
      check("rst_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
      rst = 1'b0;
      tick();

      run_cmd("add_ovf",  1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
      run_cmd("add_cout", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      run_cmd("sub_borrow", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
      run_cmd("sub_ovf",  1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

      // abort in the 4th RUN cycle; cout/ovf are 1 from the previous command
      start_cmd(1'b0, 8'hFF, 8'hFF);
      tick();
      tick();
      tick();
      check("abort_busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_state", 32'(bus.state), 32'(ST_IDLE));
      check("abort_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
      check("abort_sum", 32'(bus.sum), 32'd0);
      check("abort_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         seen_done = seen_done | bus.done;
      end
      check("abort_no_done", 32'(seen_done), 32'd0);
      run_cmd("after_abort", 1'b0, 8'h70, 8'h70, 8'hE0, 1'b0, 1'b1);

      // starts pulsed in RUN and DONE must be ignored
      start_cmd(1'b0, 8'h12, 8'h34);
      tick();
      tick();
      bus.start = 1'b1;
      bus.sub   = 1'b1;
      bus.op_a  = 8'hAA;
      bus.op_b  = 8'h55;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < WIDTH - 3; i++) tick();
      check("ign_done", 32'(bus.done), 32'd1);
      check("ign_sum_first", 32'(bus.sum), 32'h46);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("ign_idle_state", 32'(bus.state), 32'(ST_IDLE));
      tick();
      check("ign_still_idle", {30'd0, bus.busy, bus.done}, 32'd0);
      check("ign_sum_kept", 32'(bus.sum), 32'h46);
      check("ign_flags_kept", {30'd0, bus.cout, bus.ovf}, 32'd0);

      // start held high: second accept exactly WIDTH+2 edges after the first
      bus.start = 1'b1;
      bus.sub   = 1'b1;
      bus.op_a  = 8'h05;
      bus.op_b  = 8'h07;
      tick();
      bus.sub   = 1'b0;
      bus.op_a  = 8'h03;
      bus.op_b  = 8'h01;
      seen_idle = 1'b0;
      spacing   = 0;
      for (int n = 1; n <= 20 && spacing == 0; n++) begin
         tick();
         if (bus.done) check("b2b_first_sum", {23'd0, bus.cout, bus.sum}, 32'h0FE);
         if (seen_idle && bus.busy) spacing = n;
         if (bus.state == ST_IDLE) seen_idle = 1'b1;
      end
      bus.start = 1'b0;
      check("b2b_spacing", 32'(spacing), 32'd10);
      for (int i = 0; i < WIDTH; i++) tick();
      check("b2b_second_done", 32'(bus.done), 32'd1);
      check("b2b_second_sum", {22'd0, bus.cout, bus.ovf, bus.sum}, 32'h004);
      tick();
      check("b2b_end_idle", 32'(bus.state), 32'(ST_IDLE));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract controller. It sequences a single 1-bit full-adder cell over WIDTH clock cycles to add or subtract two WIDTH-bit operands, LSB first. A registered carry bit connects one bit step to the next. The block sits between the top-level pin mapping (operands and command from dedicated inputs) and the result outputs, and trades adder area for latency.

## Interface

Parameters:
- WIDTH, default 8: operand/result width in bits; legal range 2..16.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- start, input, 1: command strobe; only accepted in IDLE.
- sub, input, 1: operation select, sampled with start; 0 = A+B, 1 = A−B.
- op_a, input, WIDTH: operand A, sampled with start.
- op_b, input, WIDTH: operand B, sampled with start.
- busy, output, 1: high while in RUN.
- done, output, 1: high for exactly one cycle, while in DONE.
- sum, output, WIDTH: result; holds the last completed result until the next accepted start.
- cout, output, 1: final carry out. For subtraction, 1 means no borrow.
- ovf, output, 1: two's-complement signed overflow of the last result.

## Operation

- State machine has three states: IDLE, RUN, DONE.
  - IDLE → RUN when start=1.
  - RUN → DONE after WIDTH bit steps.
  - DONE → IDLE unconditionally on the next edge.
- Accept (IDLE with start=1):
  - shift_a ← op_a.
  - shift_b ← op_b XOR {WIDTH{sub}}.
  - carry ← sub.
  - bit count ← 0.
  - sum register cleared to 0.
- Each RUN edge:
  - The adder cell computes s = a0 ^ b0 ^ carry and c = majority(a0, b0, carry) from the LSBs of shift_a and shift_b.
  - s is shifted into the MSB of the sum shift register; shift_a and shift_b shift right by one.
  - carry ← c; count increments.
  - On the step where count = WIDTH−2, the incoming carry is captured into c_msb_in (carry into the MSB).
- Last step (count = WIDTH−1):
  - cout ← c.
  - ovf ← c XOR c_msb_in.
  - Next state is DONE.
- start is ignored in RUN and DONE. A start held high through DONE is accepted on the first IDLE cycle.
- sub, op_a and op_b are don't-care except on the accept cycle.
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, internal shift registers, carry and count 0.
- Reset asserted mid-operation aborts immediately: the next state is IDLE with all outputs at their reset values. No done is produced for the aborted command.
- Arithmetic is modulo 2^WIDTH. cout is the carry out of bit WIDTH−1 including the +1 injected for subtraction.

## Timing

- Start sampled at edge t0 → busy=1 during cycles t0+1 .. t0+WIDTH.
- done=1 during cycle t0+WIDTH+1. sum, cout and ovf are valid from that cycle and held thereafter.
- Back to IDLE at cycle t0+WIDTH+2, so minimum command spacing is WIDTH+2 cycles.
- During RUN, sum, cout and ovf hold intermediate or cleared values. Consumers read them only when done=1 or later.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- Shared package holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the count-width constant, computed from WIDTH as clog2(WIDTH).
- One sub-module, bit_full_adder (a, b, cin → s, cout), is purely combinational and instantiated once. It is the only arithmetic in the block.
- Everything else lives in serial_add_ctrl: FSM, counter, three shift registers, carry and c_msb_in flops.

## Test plan

All scenarios use WIDTH=8.
1. Addition with signed overflow: start with sub=0, op_a=0x5A, op_b=0x3C → done exactly 9 cycles after the accept edge, sum=0x96, cout=0, ovf=1. busy is high for exactly 8 cycles.
2. Addition with carry out: op_a=0xFF, op_b=0x01, sub=0 → sum=0x00, cout=1, ovf=0.
3. Subtraction with borrow: sub=1, op_a=0x10, op_b=0x20 → sum=0xF0, cout=0, ovf=0.
4. Subtraction with overflow: sub=1, op_a=0x80, op_b=0x01 → sum=0x7F, cout=1, ovf=1.
5. Ignored start: a new start with different operands pulsed during RUN and during DONE → ignored; the first result is unchanged. start held continuously → back-to-back commands exactly 10 cycles apart.
6. Reset mid-operation: rst pulsed at the 4th RUN cycle → next cycle IDLE with busy=0, done=0, sum=0, cout=0, ovf=0. No done pulse follows. A fresh start then completes correctly.
